// File: rtl/spike_pkg.sv
// Shared defaults and FSM encoding for the rate-coded spike encoder.
package spike_pkg;

    localparam int unsigned NUM_SPIKES_DEF = 10;
    localparam int unsigned WIDTH_DEF      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_t;

endpackage

// File: rtl/spike_encoder_channel.sv
// One encoder channel: rate register, phase accumulator and registered spike.
module spike_encoder_channel
    import spike_pkg::*;
#(
    parameter int unsigned WIDTH_P = WIDTH_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [WIDTH_P-1:0] wr_rate_i,
    input  logic               clr_i,
    input  logic               step_i,
    output logic               spike_o
);

    logic [WIDTH_P-1:0] rate_q;
    logic [WIDTH_P-1:0] acc_q;
    logic [WIDTH_P:0]   sum_c;

    // The carry out of the accumulator is the spike for this step.
    assign sum_c = {1'b0, acc_q} + {1'b0, rate_q};

    // Rate write, accumulator clear/advance and spike register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rate_q  <= '0;
            acc_q   <= '0;
            spike_o <= 1'b0;
        end else begin
            if (wr_en_i) begin
                rate_q <= wr_rate_i;
            end
            if (clr_i) begin
                acc_q <= '0;
            end else if (step_i) begin
                acc_q <= sum_c[WIDTH_P-1:0];
            end
            spike_o <= step_i & sum_c[WIDTH_P];
        end
    end

endmodule

// File: rtl/spike_encoder.sv
// Rate-to-spike encoder: window FSM, step counter and load decode over N channels.
module spike_encoder
    import spike_pkg::*;
#(
    parameter int unsigned NUM_SPIKES = NUM_SPIKES_DEF,
    parameter int unsigned WIDTH_P    = WIDTH_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          load_valid_i,
    output logic                          load_ready_o,
    input  logic [$clog2(NUM_SPIKES)-1:0] load_idx_i,
    input  logic [WIDTH_P-1:0]            load_rate_i,
    input  logic                          start_i,
    input  logic                          step_i,
    output logic [NUM_SPIKES-1:0]         spike_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int unsigned IDX_W = $clog2(NUM_SPIKES);
    localparam int unsigned CNT_W = WIDTH_P + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = {1'b0, {WIDTH_P{1'b1}}};

    enc_state_t              state_q;
    logic [CNT_W-1:0]        step_cnt_q;
    logic                    load_hs_c;
    logic                    start_c;
    logic                    step_c;
    logic [NUM_SPIKES-1:0]   wr_en_c;

    // Accepted load, window start and step qualifiers.
    assign load_hs_c = load_ready_o & load_valid_i;
    assign start_c   = (state_q == ST_IDLE) & start_i;
    assign step_c    = (state_q == ST_RUN) & step_i;

    // Window FSM with step counter; counter is one bit wider so it never wraps mid-window.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            step_cnt_q   <= '0;
            load_ready_o <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q      <= ST_RUN;
                        step_cnt_q   <= '0;
                        busy_o       <= 1'b1;
                        load_ready_o <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (step_i) begin
                        step_cnt_q <= step_cnt_q + CNT_W'(1);
                        if (step_cnt_q == LAST_STEP) begin
                            state_q <= ST_DONE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q      <= ST_IDLE;
                    load_ready_o <= 1'b1;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    busy_o       <= 1'b0;
                    load_ready_o <= 1'b1;
                end
            endcase
        end
    end

    // Per-channel write decode; out-of-range indices match no channel.
    for (genvar c = 0; c < NUM_SPIKES; c++) begin : g_ch
        assign wr_en_c[c] = load_hs_c && (load_idx_i == IDX_W'(c));

        spike_encoder_channel #(
            .WIDTH_P(WIDTH_P)
        ) u_channel (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .wr_en_i  (wr_en_c[c]),
            .wr_rate_i(load_rate_i),
            .clr_i    (start_c),
            .step_i   (step_c),
            .spike_o  (spike_o[c])
        );
    end

endmodule

// File: tb/tb_spike_encoder.sv
// Randomized scoreboard bench for spike_encoder against an arithmetic rate model.
module tb_spike_encoder;
    import spike_pkg::*;

    localparam int unsigned N  = 10;
    localparam int unsigned W  = 8;
    localparam int unsigned IW = $clog2(N);
    localparam int STEPS = 1 << W;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic          load_ready;
    logic [IW-1:0] load_idx;
    logic [W-1:0]  load_rate;
    logic          start;
    logic          step;
    logic [N-1:0]  spike;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    spike_encoder #(
        .NUM_SPIKES(N),
        .WIDTH_P   (W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_valid_i(load_valid),
        .load_ready_o(load_ready),
        .load_idx_i  (load_idx),
        .load_rate_i (load_rate),
        .start_i     (start),
        .step_i      (step),
        .spike_o     (spike),
        .busy_o      (busy),
        .done_o      (done)
    );

    typedef struct packed {
        logic [N-1:0]        spike;
        logic                busy;
        logic                done;
        logic                ready;
        logic                clr_cnt;
        logic [N-1:0][W-1:0] tot;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: window phase, steps taken and programmed rates.
    int   mode = 0;   // 0 idle, 1 running, 2 window just finished
    int   k    = 0;
    int   mrate[N];

    function automatic void check(input string name, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endfunction

    // One clock of stimulus; the model predicts the outputs seen after this edge.
    task automatic cycle(input bit v, input int idx, input int r, input bit st,
                         input bit sp, input bit rs);
        exp_t e;
        rst        = rs;
        load_valid = v;
        load_idx   = IW'(idx);
        load_rate  = W'(r);
        start      = st;
        step       = sp;
        e = '0;
        if (rs) begin
            for (int c = 0; c < N; c++) mrate[c] = 0;
            mode      = 0;
            k         = 0;
            e.ready   = 1'b1;
            e.clr_cnt = 1'b1;
        end else begin
            case (mode)
                0: begin
                    if (v && idx < N) mrate[idx] = r;
                    if (st) begin
                        mode      = 1;
                        k         = 0;
                        e.busy    = 1'b1;
                        e.clr_cnt = 1'b1;
                    end else begin
                        e.ready = 1'b1;
                    end
                end
                1: begin
                    e.busy = 1'b1;
                    if (sp) begin
                        k++;
                        for (int c = 0; c < N; c++)
                            e.spike[c] = ((k * mrate[c]) / STEPS) != (((k - 1) * mrate[c]) / STEPS);
                        if (k == STEPS) begin
                            mode   = 2;
                            e.busy = 1'b0;
                            e.done = 1'b1;
                            for (int c = 0; c < N; c++) e.tot[c] = W'(mrate[c]);
                        end
                    end
                end
                default: begin
                    mode    = 0;
                    e.ready = 1'b1;
                end
            endcase
        end
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input int idx, input int r);
        cycle(1, idx, r, 0, 0, 0);
    endtask

    // Start a window (optionally with a coincident load) and step it to completion.
    // pat: 0 continuous, 1 toggling, 2 random. rst_at > 0 resets after that many steps.
    task automatic window(input int pat, input int rst_at, input bit ld_run,
                          input bit sv, input int sidx, input int sr);
        int guard;
        bit sp;
        bit v;
        cycle(sv, sidx, sr, 1, 0, 0);
        guard = 0;
        while (mode == 1 && guard < 4 * STEPS) begin
            if (rst_at > 0 && k == rst_at) begin
                cycle(0, 0, 0, 0, 0, 1);
                break;
            end
            case (pat)
                0:       sp = 1'b1;
                1:       sp = (guard % 2) == 0;
                default: sp = $urandom_range(0, 3) != 0;
            endcase
            v = ld_run ? bit'($urandom_range(0, 1)) : 1'b0;
            cycle(v, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)),
                  bit'($urandom_range(0, 1)), sp, 0);
            guard++;
        end
        if (mode == 2) cycle(0, 0, 0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
    endtask

    // Monitor: pop one expectation per cycle and compare, tallying spikes per channel.
    initial begin
        int   obs[N];
        exp_t e;
        for (int c = 0; c < N; c++) obs[c] = 0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.clr_cnt) for (int c = 0; c < N; c++) obs[c] = 0;
                check("spike_o", int'(spike), int'(e.spike));
                check("busy_o", int'(busy), int'(e.busy));
                check("done_o", int'(done), int'(e.done));
                check("load_ready_o", int'(load_ready), int'(e.ready));
                for (int c = 0; c < N; c++) obs[c] += int'(spike[c]);
                if (e.done) begin
                    for (int c = 0; c < N; c++)
                        check($sformatf("spike_count_%0d", c), obs[c], int'(e.tot[c]));
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        rst = 1'b1; load_valid = 1'b0; load_idx = '0; load_rate = '0;
        start = 1'b0; step = 1'b0;
        for (int c = 0; c < N; c++) mrate[c] = 0;

        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        idle(2);

        // Boundary rates, continuous steps then toggling steps.
        load(0, 0);
        load(1, 128);
        load(2, 1);
        load(3, 255);
        window(0, 0, 0, 0, 0, 0);
        idle(1);
        window(1, 0, 0, 0, 0, 0);

        // Random rates on every channel with random stepping.
        for (int c = 0; c < N; c++) load(c, int'($urandom_range(0, 255)));
        window(2, 0, 0, 0, 0, 0);

        // Loads attempted during RUN must be refused.
        window(2, 0, 1, 0, 0, 0);

        // Out-of-range indices ignored; load coincident with start takes effect.
        load(12, 77);
        load(15, 33);
        window(0, 0, 0, 1, 5, 200);

        // Reset mid-window, then a window with no loads stays silent.
        for (int c = 0; c < N; c++) load(c, int'($urandom_range(1, 255)));
        window(0, 100, 0, 0, 0, 0);
        idle(2);
        window(2, 0, 0, 0, 0, 0);

        idle(3);
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 SHALL have parameter NUM_SPIKES, default 10, number of spike channels.
REQ-002 SHALL have parameter WIDTH_P, default 8, rate width; one encoding window is 2^WIDTH_P steps.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port load_valid_i, input, 1, rate-write request.
REQ-006 SHALL have port load_ready_o, output, 1, rate write accepted this cycle when high with load_valid_i.
REQ-007 SHALL have port load_idx_i, input, $clog2(NUM_SPIKES), target channel.
REQ-008 SHALL have port load_rate_i, input, WIDTH_P, spikes per window for that channel.
REQ-009 SHALL have port start_i, input, 1, begin an encoding window.
REQ-010 SHALL have port step_i, input, 1, timestep enable; one step per cycle when high in RUN.
REQ-011 SHALL have port spike_o, output, NUM_SPIKES, one-cycle spike per channel.
REQ-012 SHALL have port busy_o, output, 1, high in RUN.
REQ-013 SHALL have port done_o, output, 1, single-cycle window-complete pulse.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; transitions are IDLE->RUN on start_i, RUN->DONE after the 2^WIDTH_P-th accepted step, and DONE->IDLE unconditionally after one cycle.
REQ-015 SHALL drive load_ready_o high only in IDLE; a handshake writes load_rate_i into rate[load_idx_i] at that edge.
REQ-016 SHALL ignore handshakes whose load_idx_i >= NUM_SPIKES, leaving all rates unchanged.
REQ-017 SHALL, on IDLE->RUN, clear all channel accumulators and the step counter; the rates are retained.
REQ-018 SHALL, when load and start coincide in IDLE, perform the write and enter RUN, with the window using the newly written rate.
REQ-019 SHALL, per accepted step, compute {carry, acc[c]} = acc[c] + rate[c] (WIDTH_P+1 bits), store the low WIDTH_P bits, and register carry into spike_o[c].
REQ-020 SHALL assert spike_o exactly one cycle after the accepted step; spike_o is 0 in every other cycle, including cycles with step_i low.
REQ-021 SHALL make each channel emit exactly rate[c] spikes per window, with rate 0 emitting none and rate 2^WIDTH_P-1 emitting 2^WIDTH_P-1.
REQ-022 SHALL use a step counter of WIDTH_P+1 bits; it must not wrap before the window ends.
REQ-023 SHALL ignore start_i in RUN and DONE, and ignore step_i outside RUN.
REQ-024 SHALL assert done_o in the DONE cycle, coincident with the spike_o of the final step.
REQ-025 SHALL keep busy_o low in IDLE and DONE.

Reset
REQ-026 SHALL, on rst_i high at a clock edge, enter IDLE and clear rates, accumulators and step counter; spike_o, busy_o and done_o become 0 and load_ready_o becomes 1 the following cycle.
REQ-027 SHALL, on reset mid-RUN, abort the window without a done_o pulse; a subsequent window needs fresh loads.

Structure
REQ-028 SHALL take NUM_SPIKES/WIDTH_P defaults and the FSM state encoding from shared package spike_pkg.
REQ-029 SHALL instantiate sub-module spike_encoder_channel per channel, holding the rate register, accumulator and spike flop.
REQ-030 SHALL keep the FSM, step counter and load decode in the top level.

Verification
REQ-031 SHALL check: load ch0 = 0, start, 256 continuous steps -> spike_o[0] never high, done_o one pulse.
REQ-032 SHALL check: ch1 = 128 -> spikes on steps 2,4,...,256, 128 total; ch2 = 1 -> single spike on step 256 with done_o.
REQ-033 SHALL check: ch3 = 255, step_i toggling 1/0 -> 255 spikes, never in a cycle after step_i low, window spans 512 cycles.
REQ-034 SHALL check: random rates on all 10 channels, spike_o looped into the spike counter -> each spike_count_c equals rate c after done_o.
REQ-035 SHALL check: assert rst_i at step 100 -> spike_o/busy_o 0 next cycle, no done_o, rates read back as 0 (next window silent).
REQ-036 SHALL check: load_valid_i in RUN -> load_ready_o 0 and rate unchanged; load idx 12 in IDLE -> ignored; load+start same cycle -> new rate used.
